// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_pkg
// Purpose  : Shared types and helpers for the scan chain controller:
//            sequencer state encoding and the shift-counter width function.
// Revision : 1.0 - initial release
// ============================================================================
package scan_pkg;

  // Sequencer states. The explicit width keeps the encoding stable across tools.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_chain.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain
// Purpose  : One chain of CHAIN_LEN mux-D scan cells.
//            Priority: functional/capture load > shift > hold.
// Ports    : clk, reset      - clock, async active-high reset
//            func_sel        - functional mode, load func_d every edge
//            scan_en         - shift SI into cell0 towards cell CHAIN_LEN-1
//            capture         - load func_d (test-mode capture)
//            si              - serial input bit
//            func_d [L-1:0]  - CUT next-state slice
//            q      [L-1:0]  - cell state, bit i = cell i
//            so              - serial output (cell CHAIN_LEN-1)
// Revision : 1.0 - initial release
// ============================================================================
module scan_chain #(
  parameter int CHAIN_LEN = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 func_sel,
  input  logic                 scan_en,
  input  logic                 capture,
  input  logic                 si,
  input  logic [CHAIN_LEN-1:0] func_d,
  output logic [CHAIN_LEN-1:0] q,
  output logic                 so
);

  logic [CHAIN_LEN-1:0] cells_q;
  logic [CHAIN_LEN-1:0] cells_d;
  logic [CHAIN_LEN-1:0] shift_w;

  // cell0 takes SI, every other cell takes its lower neighbour.
  if (CHAIN_LEN == 1) begin : g_single
    assign shift_w = si;
  end else begin : g_multi
    assign shift_w = {cells_q[CHAIN_LEN-2:0], si};
  end

  always_comb begin
    cells_d = cells_q;
    if (func_sel || capture) begin
      cells_d = func_d;
    end else if (scan_en) begin
      cells_d = shift_w;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cells_q <= '0;
    end else begin
      cells_q <= cells_d;
    end
  end

  assign q  = cells_q;
  assign so = cells_q[CHAIN_LEN-1];

endmodule
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_ctrl
// Purpose  : Multi-chain scan wrapper with an on-chip load/capture/unload
//            sequencer. Unload of each response overlaps the next load.
// Ports    : clk, reset            - clock, async active-high reset
//            TM                    - 0 functional, 1 scan sequencer enabled
//            start                 - session request (IDLE, TM=1 only)
//            num_patterns [PAT_W]  - pattern count, sampled on accepted start
//            SI  [NUM_CHAINS]      - scan-in per chain
//            func_d [NC*CL]        - CUT next-state, chain c cell i = c*CL+i
//            q      [NC*CL]        - scan-cell state to the CUT
//            SO  [NUM_CHAINS]      - scan-out, last cell of each chain
//            scan_en/capture/so_valid/busy/done - registered-state decodes
// Revision : 1.0 - initial release
// ============================================================================
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int NUM_CHAINS = 2,
  parameter int CHAIN_LEN  = 3,
  parameter int PAT_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            TM,
  input  logic                            start,
  input  logic [PAT_W-1:0]                num_patterns,
  input  logic [NUM_CHAINS-1:0]           SI,
  input  logic [NUM_CHAINS*CHAIN_LEN-1:0] func_d,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0] q,
  output logic [NUM_CHAINS-1:0]           SO,
  output logic                            scan_en,
  output logic                            capture,
  output logic                            so_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int             SH_W    = cnt_width(CHAIN_LEN);
  localparam logic [SH_W-1:0] SH_LAST = SH_W'(CHAIN_LEN - 1);

  state_e            state_q,   state_d;
  logic [SH_W-1:0]   sh_cnt_q,  sh_cnt_d;
  logic [PAT_W-1:0]  pat_cnt_q, pat_cnt_d;
  logic [PAT_W-1:0]  npat_q,    npat_d;

  always_comb begin
    state_d   = state_q;
    sh_cnt_d  = sh_cnt_q;
    pat_cnt_d = pat_cnt_q;
    npat_d    = npat_q;
    if (!TM) begin
      // Leaving test mode abandons the session without a done pulse.
      state_d   = S_IDLE;
      sh_cnt_d  = '0;
      pat_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (num_patterns != '0)) begin
            state_d   = S_SHIFT;
            sh_cnt_d  = '0;
            pat_cnt_d = '0;
            npat_d    = num_patterns;
          end
        end
        S_SHIFT: begin
          if (sh_cnt_q == SH_LAST) begin
            sh_cnt_d = '0;
            state_d  = S_CAPTURE;
          end else begin
            sh_cnt_d = sh_cnt_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          // npat_q is never zero inside a session, so the subtract is safe.
          if (pat_cnt_q != (npat_q - 1'b1)) begin
            pat_cnt_d = pat_cnt_q + 1'b1;
            state_d   = S_SHIFT;
          end else begin
            state_d   = S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (sh_cnt_q == SH_LAST) begin
            sh_cnt_d = '0;
            state_d  = S_DONE;
          end else begin
            sh_cnt_d = sh_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          pat_cnt_d = '0;
          state_d   = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sh_cnt_q  <= '0;
      pat_cnt_q <= '0;
      npat_q    <= '0;
    end else begin
      state_q   <= state_d;
      sh_cnt_q  <= sh_cnt_d;
      pat_cnt_q <= pat_cnt_d;
      npat_q    <= npat_d;
    end
  end

  // All status outputs decode registered state only.
  assign scan_en  = (state_q == S_SHIFT) || (state_q == S_UNLOAD);
  assign capture  = (state_q == S_CAPTURE);
  // Any shift after the first capture carries a response out on SO.
  assign so_valid = (state_q == S_UNLOAD) ||
                    ((state_q == S_SHIFT) && (pat_cnt_q != '0));
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
    scan_chain #(
      .CHAIN_LEN (CHAIN_LEN)
    ) u_chain (
      .clk      (clk),
      .reset    (reset),
      .func_sel (~TM),
      .scan_en  (scan_en),
      .capture  (capture),
      .si       (SI[c]),
      .func_d   (func_d[c*CHAIN_LEN +: CHAIN_LEN]),
      .q        (q[c*CHAIN_LEN +: CHAIN_LEN]),
      .so       (SO[c])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_chain_ctrl
// Purpose  : Self-checking bench for scan_chain_ctrl. A schedule-based model
//            (queue of pending shift/capture/done operations) predicts every
//            output each cycle; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_chain_ctrl;

  localparam int NC = 2;
  localparam int CL = 3;
  localparam int PW = 8;
  localparam int NQ = NC * CL;

  logic          clk = 1'b0;
  logic          reset;
  logic          TM;
  logic          start;
  logic [PW-1:0] num_patterns;
  logic [NC-1:0] SI;
  logic [NQ-1:0] func_d;
  logic [NQ-1:0] q;
  logic [NC-1:0] SO;
  logic          scan_en, capture, so_valid, busy, done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  scan_chain_ctrl #(
    .NUM_CHAINS (NC),
    .CHAIN_LEN  (CL),
    .PAT_W      (PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .TM           (TM),
    .start        (start),
    .num_patterns (num_patterns),
    .SI           (SI),
    .func_d       (func_d),
    .q            (q),
    .SO           (SO),
    .scan_en      (scan_en),
    .capture      (capture),
    .so_valid     (so_valid),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {OP_SHIFT, OP_CAP, OP_DONE} op_e;
  typedef struct {
    op_e kind;
    bit  sov;
  } op_t;

  op_t           sched[$];
  logic [NQ-1:0] m_q;

  always @(posedge clk or posedge reset) begin : model
    logic [NQ-1:0] nq;
    op_t           op;
    if (reset) begin
      m_q <= '0;
      sched.delete();
    end else if (!TM) begin
      m_q <= func_d;
      sched.delete();
    end else if (sched.size() != 0) begin
      op = sched.pop_front();
      nq = m_q;
      if (op.kind == OP_SHIFT) begin
        for (int c = 0; c < NC; c++) begin
          for (int i = CL - 1; i >= 1; i--) nq[c*CL+i] = m_q[c*CL+i-1];
          nq[c*CL] = SI[c];
        end
      end else if (op.kind == OP_CAP) begin
        nq = func_d;
      end
      m_q <= nq;
    end else if (start && num_patterns != '0) begin
      for (int p = 0; p < int'(num_patterns); p++) begin
        for (int s = 0; s < CL; s++) sched.push_back('{OP_SHIFT, (p != 0)});
        sched.push_back('{OP_CAP, 1'b0});
      end
      for (int s = 0; s < CL; s++) sched.push_back('{OP_SHIFT, 1'b1});
      sched.push_back('{OP_DONE, 1'b0});
    end
  end

  always @(negedge clk) begin : compare
    logic [NC-1:0] e_so;
    logic          e_se, e_cap, e_sov, e_busy, e_done;
    e_se = 1'b0; e_cap = 1'b0; e_sov = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (sched.size() != 0) begin
      e_busy = 1'b1;
      case (sched[0].kind)
        OP_SHIFT: begin e_se = 1'b1; e_sov = sched[0].sov; end
        OP_CAP:   e_cap  = 1'b1;
        default:  e_done = 1'b1;
      endcase
    end
    for (int c = 0; c < NC; c++) e_so[c] = m_q[c*CL+CL-1];
    check("cycle{q,SO,se,cap,sov,busy,done}",
          64'({q, SO, scan_en, capture, so_valid, busy, done}),
          64'({m_q, e_so, e_se, e_cap, e_sov, e_busy, e_done}));
  end

  // ---------------- activity counters ----------------
  int n_se = 0, n_cap = 0, n_sov = 0, n_busy = 0, n_done = 0;
  always @(negedge clk) begin
    n_se   <= n_se   + int'(scan_en);
    n_cap  <= n_cap  + int'(capture);
    n_sov  <= n_sov  + int'(so_valid);
    n_busy <= n_busy + int'(busy);
    n_done <= n_done + int'(done);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int s_se, s_cap, s_sov, s_busy, s_done;
    reset = 1'b1; TM = 1'b0; start = 1'b0; num_patterns = '0; SI = '0; func_d = '0;
    repeat (2) tick();
    check("reset_q", 64'(q), 64'(0));
    check("reset_SO", 64'(SO), 64'(0));
    check("reset_flags", 64'({scan_en, capture, so_valid, busy, done}), 64'(0));
    reset = 1'b0;

    // Functional mode: q follows func_d, start ignored.
    func_d = 6'b101_011; start = 1'b1; num_patterns = 8'd1;
    tick();
    check("func_q", 64'(q), 64'(6'b101_011));
    check("func_busy", 64'(busy), 64'(0));
    func_d = 6'b010_110;
    tick();
    check("func_q2", 64'(q), 64'(6'b010_110));
    start = 1'b0;
    tick();

    // Single-pattern session with known load and response.
    TM = 1'b1;
    tick();
    s_se = n_se; s_cap = n_cap; s_sov = n_sov; s_busy = n_busy; s_done = n_done;
    start = 1'b1; num_patterns = 8'd1;
    tick();
    start = 1'b0; num_patterns = 8'd5;
    SI = 2'b01; tick();
    SI = 2'b10; tick();
    SI = 2'b01; tick();
    check("load_chain0", 64'(q[2:0]), 64'(3'b101));
    check("load_chain1", 64'(q[5:3]), 64'(3'b010));
    check("load_se_cycles", 64'(n_se - s_se), 64'(3));
    check("load_sov_cycles", 64'(n_sov - s_sov), 64'(0));
    func_d = {3'b001, 3'b110};
    tick();
    check("unload_SO0_a", 64'(SO[0]), 64'(1));
    SI = 2'b00;
    tick();
    check("unload_SO0_b", 64'(SO[0]), 64'(1));
    tick();
    check("unload_SO0_c", 64'(SO[0]), 64'(0));
    tick();
    check("done_pulse", 64'({done, busy}), 64'(2'b11));
    tick();
    check("after_done", 64'({done, busy}), 64'(0));
    tick();
    check("s1_capture_cnt", 64'(n_cap - s_cap), 64'(1));
    check("s1_done_cnt", 64'(n_done - s_done), 64'(1));
    check("s1_busy_cnt", 64'(n_busy - s_busy), 64'(8));
    check("s1_sov_cnt", 64'(n_sov - s_sov), 64'(3));
    check("s1_se_cnt", 64'(n_se - s_se), 64'(6));

    // Two patterns: overlapped unload/load.
    s_cap = n_cap; s_sov = n_sov; s_busy = n_busy; s_done = n_done;
    start = 1'b1; num_patterns = 8'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      SI = NC'($urandom); func_d = NQ'($urandom);
      tick();
    end
    check("s2_busy_cnt", 64'(n_busy - s_busy), 64'(12));
    check("s2_capture_cnt", 64'(n_cap - s_cap), 64'(2));
    check("s2_done_cnt", 64'(n_done - s_done), 64'(1));
    check("s2_sov_cnt", 64'(n_sov - s_sov), 64'(6));

    // Zero patterns, start while busy, TM dropped mid-SHIFT.
    s_busy = n_busy; s_done = n_done;
    start = 1'b1; num_patterns = 8'd0;
    tick();
    start = 1'b0;
    tick();
    check("zero_pat_busy", 64'(n_busy - s_busy), 64'(0));
    s_done = n_done;
    start = 1'b1; num_patterns = 8'd3;
    tick();
    start = 1'b1; num_patterns = 8'd1;
    tick();
    start = 1'b0;
    tick();
    TM = 1'b0; func_d = 6'b110_001;
    tick();
    check("tm_drop_busy", 64'({busy, done}), 64'(0));
    check("tm_drop_q", 64'(q), 64'(6'b110_001));
    TM = 1'b1;
    tick();
    check("tm_drop_done_cnt", 64'(n_done - s_done), 64'(0));

    // Asynchronous reset in the middle of SHIFT.
    start = 1'b1; num_patterns = 8'd2;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("midreset_q", 64'(q), 64'(0));
    check("midreset_SO", 64'(SO), 64'(0));
    check("midreset_flags", 64'({busy, scan_en}), 64'(0));
    tick();
    reset = 1'b0;
    tick();
    s_busy = n_busy; s_done = n_done;
    start = 1'b1; num_patterns = 8'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      SI = NC'($urandom); func_d = NQ'($urandom);
      tick();
    end
    check("fresh_busy_cnt", 64'(n_busy - s_busy), 64'(8));
    check("fresh_done_cnt", 64'(n_done - s_done), 64'(1));

    // Maximum pattern count.
    s_cap = n_cap; s_busy = n_busy; s_done = n_done;
    start = 1'b1; num_patterns = 8'd255;
    tick();
    start = 1'b0;
    for (int i = 0; i < 1025; i++) begin
      SI = NC'($urandom); func_d = NQ'($urandom);
      tick();
    end
    check("max_busy_cnt", 64'(n_busy - s_busy), 64'(1024));
    check("max_capture_cnt", 64'(n_cap - s_cap), 64'(255));
    check("max_done_cnt", 64'(n_done - s_done), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
